// File: rtl/spi_pkg.sv
`default_nettype none
//============================================================================
// Module   : spi_pkg
// Brief    : Shared types and constants for the SPI controller slice:
//            controller state encoding, byte width, counter widths.
// Revision : 1.0 - initial release
//============================================================================
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_BIT_W  = $clog2(SPI_BYTE_W);
    localparam int SPI_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        SCK_HIGH  = 3'd2,
        SCK_LOW   = 3'd3,
        WAIT_NEXT = 3'd4,
        HOLD      = 3'd5,
        GAP       = 3'd6
    } spi_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_half_period_counter.sv
`default_nettype none
//============================================================================
// Module   : spi_half_period_counter
// Brief    : Down-counter that times one sck half-period. Reloads to
//            CLK_DIV-1 whenever the controller enters a new state and
//            flags o_tick on the last cycle of the half-period.
// Revision : 1.0 - initial release
//============================================================================
module spi_half_period_counter
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_tick
);

    localparam logic [SPI_CNT_W-1:0] c_RELOAD = SPI_CNT_W'(CLK_DIV - 1);

    logic [SPI_CNT_W-1:0] r_cnt;

    // Reload on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule : spi_half_period_counter
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
//============================================================================
// Module   : spi_controller
// Brief    : SPI mode-0 master. Accepts bytes over a valid/ready stream,
//            shifts them out MSB first while sampling miso, and returns
//            each received byte as a one-cycle rx_valid pulse. Frames are
//            delimited by tx_last; ss stays low between bytes of a frame.
// Config   : SPI_CTRL_LOOPBACK_EN - adds input 'loopback'; when high the
//            receive shifter samples the outgoing mosi bit instead of miso.
// Revision : 1.0 - initial release
//============================================================================
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_last,
    output logic                  rx_valid,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  busy,
    output logic                  sck,
    output logic                  ss,
    output logic                  mosi,
    input  logic                  miso
`ifdef SPI_CTRL_LOOPBACK_EN
    ,
    input  logic                  loopback
`endif
);

    localparam logic [SPI_BIT_W-1:0] c_LAST_BIT = SPI_BIT_W'(SPI_BYTE_W - 1);

    spi_state_t            r_state;
    spi_state_t            w_next;
    logic                  w_tick;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_byte_done;
    logic                  w_enter_high;
    logic                  w_enter_low;
    logic                  w_sample;

    logic                  r_tx_ready;
    logic                  r_rx_valid;
    logic [SPI_BYTE_W-1:0] r_rx_data;
    logic                  r_sck;
    logic                  r_ss;
    logic                  r_last;
    logic [SPI_BYTE_W-1:0] r_shift_tx;
    logic [SPI_BYTE_W-1:0] r_shift_rx;
    logic [SPI_BIT_W-1:0]  r_bit_cnt;

    assign w_accept     = tx_valid && r_tx_ready;
    assign w_load       = (w_next != r_state);
    assign w_enter_high = (w_next == SCK_HIGH) && (r_state != SCK_HIGH);
    assign w_enter_low  = (w_next == SCK_LOW)  && (r_state != SCK_LOW);

`ifdef SPI_CTRL_LOOPBACK_EN
    assign w_sample = loopback ? r_shift_tx[SPI_BYTE_W-1] : miso;
`else
    assign w_sample = miso;
`endif

    spi_half_period_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_half_period (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .o_tick (w_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; each timed state lasts one counter half-period.
    always_comb begin
        w_next      = r_state;
        w_byte_done = 1'b0;
        case (r_state)
            IDLE, WAIT_NEXT: begin
                if (w_accept) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_next = SCK_HIGH;
                end
            end
            SCK_HIGH: begin
                if (w_tick) begin
                    w_next = SCK_LOW;
                end
            end
            SCK_LOW: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_byte_done = 1'b1;
                        w_next      = r_last ? HOLD : WAIT_NEXT;
                    end else begin
                        w_next = SCK_HIGH;
                    end
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_next = GAP;
                end
            end
            GAP: begin
                if (w_tick) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Pin and handshake registers follow the state being entered so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_ready <= 1'b0;
            r_sck      <= 1'b0;
            r_ss       <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_tx_ready <= (w_next == IDLE) || (w_next == WAIT_NEXT);
            r_sck      <= (w_next == SCK_HIGH);
            r_ss       <= (w_next == IDLE) || (w_next == GAP);
            r_rx_valid <= w_byte_done;
            if (w_byte_done) begin
                r_rx_data <= r_shift_rx;
            end
        end
    end

    // Shift registers and bit counter: load on accept, sample on rising
    // sck, advance mosi on falling sck except after the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_tx <= '0;
            r_shift_rx <= '0;
            r_last     <= 1'b0;
            r_bit_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_shift_tx <= tx_data;
                r_last     <= tx_last;
                r_bit_cnt  <= '0;
            end else begin
                if (w_enter_low && (r_bit_cnt != c_LAST_BIT)) begin
                    r_shift_tx <= {r_shift_tx[SPI_BYTE_W-2:0], 1'b0};
                end
                if ((r_state == SCK_LOW) && w_tick && !w_byte_done) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            if (w_enter_high) begin
                r_shift_rx <= {r_shift_rx[SPI_BYTE_W-2:0], w_sample};
            end
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = (r_state != IDLE);
    assign sck      = r_sck;
    assign ss       = r_ss;
    assign mosi     = r_shift_tx[SPI_BYTE_W-1];

endmodule : spi_controller
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
//============================================================================
// Module   : tb_spi_controller
// Brief    : Bench for spi_controller. Two instances (CLK_DIV=4 and 1),
//            each with an SPI mode-0 peripheral model, a timeline model of
//            the expected pin/handshake behaviour, and directed checks.
// Revision : 1.0 - initial release
//============================================================================
module tb_spi_controller;

    localparam int D0 = 4;
    localparam int D1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [1:0]           tx_valid;
    logic [1:0]           tx_ready;
    logic [1:0]           tx_last;
    logic [1:0]           rx_valid;
    logic [1:0]           busy;
    logic [1:0]           sck;
    logic [1:0]           ss;
    logic [1:0]           mosi;
    logic [1:0]           miso;
    logic [1:0]           p_miso;
    logic [1:0][7:0]      tx_data;
    logic [1:0][7:0]      rx_data;
    logic [1:0][7:0]      drv_miso;
    logic [7:0]           tab [2][4];
    int                   widx [2];
    int                   acc  [2];
    int                   cyc = 0;
    int                   n_cmp = 0;
    int                   n_err = 0;
`ifdef SPI_CTRL_LOOPBACK_EN
    logic                 lb = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    spi_controller #(.CLK_DIV(D0)) u_dut4 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx_data(tx_data[0]), .tx_last(tx_last[0]), .rx_valid(rx_valid[0]),
        .rx_data(rx_data[0]), .busy(busy[0]), .sck(sck[0]), .ss(ss[0]),
        .mosi(mosi[0]), .miso(miso[0])
`ifdef SPI_CTRL_LOOPBACK_EN
        , .loopback(lb)
`endif
    );

    spi_controller #(.CLK_DIV(D1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx_data(tx_data[1]), .tx_last(tx_last[1]), .rx_valid(rx_valid[1]),
        .rx_data(rx_data[1]), .busy(busy[1]), .sck(sck[1]), .ss(ss[1]),
        .mosi(mosi[1]), .miso(miso[1])
`ifdef SPI_CTRL_LOOPBACK_EN
        , .loopback(lb)
`endif
    );

    // Mode-0 peripheral: shifts out tab[] bytes on falling sck, captures
    // mosi on rising sck; bit position restarts whenever ss is high.
    for (genvar g = 0; g < 2; g++) begin : g_periph
        int         pos  = 0;
        int         rcnt = 0;
        int         gcnt = 0;
        logic [7:0] rsh  = 8'h00;
        logic [7:0] got [16];

        always @(posedge ss[g] or negedge sck[g]) begin
            if (ss[g] !== 1'b0) pos = 0;
            else                pos = pos + 1;
        end

        always @(posedge sck[g] or posedge ss[g]) begin
            if (ss[g] !== 1'b0) begin
                rcnt = 0;
            end else begin
                rsh  = {rsh[6:0], mosi[g]};
                rcnt = rcnt + 1;
                if (rcnt == 8) begin
                    got[gcnt % 16] = rsh;
                    gcnt = gcnt + 1;
                    rcnt = 0;
                end
            end
        end

        assign p_miso[g] = tab[g][(pos >> 3) & 3][7 - (pos & 7)];
`ifdef SPI_CTRL_LOOPBACK_EN
        assign miso[g] = lb ? 1'b0 : p_miso[g];
`else
        assign miso[g] = p_miso[g];
`endif
    end

    task automatic chk(input string nm, input int ch, input logic [31:0] a, input logic [31:0] e);
        n_cmp = n_cmp + 1;
        if (a !== e) begin
            n_err = n_err + 1;
            $display("FAIL %s ch%0d: got %0h expected %0h (t=%0t)", nm, ch, a, e, $time);
        end
    endtask

    // ---------------- timeline model + per-cycle compare ----------------
    // o = rising edges since the accept edge. Byte timeline for divider D:
    // [0,D) select set up, then 8 sck periods (high first), rx pulse at 17D;
    // final byte then holds ss low for D, deselects for D, idles at 19D.
    bit         m_st   [2];
    bit         m_inr  [2];
    bit         m_act  [2];
    bit         m_lst  [2];
    int         m_o    [2];
    logic [7:0] m_dat  [2];
    logic [7:0] m_mexp [2];
    logic [7:0] m_rxh  [2];
    int         m_rxvn [2];
    int         m_dv, m_k;
    bit         e_ss, e_sck, e_rdy, e_rxv, e_busy, e_chkm;
    logic       e_mosi;

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            m_dv  = (ch == 0) ? D0 : D1;
            e_rdy = 1'b0;
            if (m_st[ch]) begin
                e_chkm = 1'b0;
                e_mosi = 1'b0;
                if (m_inr[ch]) begin
                    e_ss = 1; e_sck = 0; e_rdy = 0; e_rxv = 0; e_busy = 0; e_chkm = 1;
                end else if (!m_act[ch]) begin
                    e_ss = 1; e_sck = 0; e_rdy = 1; e_rxv = 0; e_busy = 0;
                end else if (m_o[ch] < 17 * m_dv) begin
                    e_ss = 0; e_busy = 1; e_rdy = 0; e_rxv = 0;
                    e_sck = (m_o[ch] >= m_dv) && ((((m_o[ch] - m_dv) / m_dv) % 2) == 0);
                    if (e_sck) begin
                        m_k    = (m_o[ch] - m_dv) / (2 * m_dv);
                        e_mosi = m_dat[ch][7 - m_k];
                        e_chkm = 1'b1;
                    end
                end else begin
                    e_sck = 0;
                    e_rxv = (m_o[ch] == 17 * m_dv);
                    if (!m_lst[ch])              begin e_ss = 0; e_busy = 1; e_rdy = 1; end
                    else if (m_o[ch] < 18 * m_dv) begin e_ss = 0; e_busy = 1; e_rdy = 0; end
                    else                          begin e_ss = 1; e_busy = 1; e_rdy = 0; end
                end
                chk("ss",       ch, 32'(ss[ch]),       32'(e_ss));
                chk("sck",      ch, 32'(sck[ch]),      32'(e_sck));
                chk("tx_ready", ch, 32'(tx_ready[ch]), 32'(e_rdy));
                chk("rx_valid", ch, 32'(rx_valid[ch]), 32'(e_rxv));
                chk("busy",     ch, 32'(busy[ch]),     32'(e_busy));
                chk("rx_data",  ch, 32'(rx_data[ch]),  32'(m_rxh[ch]));
                if (e_chkm) chk("mosi", ch, 32'(mosi[ch]), 32'(e_mosi));
                if (rx_valid[ch] === 1'b1) m_rxvn[ch] = m_rxvn[ch] + 1;
            end
            // advance to the state after the coming rising edge
            if (rst === 1'b1) begin
                m_st[ch] = 1; m_inr[ch] = 1; m_act[ch] = 0; m_rxh[ch] = 8'h00;
            end else if (m_st[ch]) begin
                m_inr[ch] = 0;
                if (tx_valid[ch] === 1'b1 && e_rdy) begin
                    m_act[ch] = 1; m_o[ch] = 0; m_lst[ch] = tx_last[ch]; m_dat[ch] = tx_data[ch];
                    m_mexp[ch] = drv_miso[ch];
`ifdef SPI_CTRL_LOOPBACK_EN
                    if (lb) m_mexp[ch] = tx_data[ch];
`endif
                end else if (m_act[ch]) begin
                    m_o[ch] = m_o[ch] + 1;
                    if (m_o[ch] == 17 * m_dv) m_rxh[ch] = m_mexp[ch];
                    if (m_lst[ch] && m_o[ch] >= 19 * m_dv) m_act[ch] = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_to(input int t);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc < t && guard < 20000);
    endtask

    // Offer one byte and hold it until the accept edge; records that edge.
    task automatic send_byte(input int ch, input logic [7:0] d, input logic l, input logic [7:0] m);
        int n = 0;
        tab[ch][widx[ch] % 4] = m;
        widx[ch]     = l ? 0 : widx[ch] + 1;
        drv_miso[ch] = m;
        tx_data[ch]  = d;
        tx_last[ch]  = l;
        tx_valid[ch] = 1'b1;
        while (tx_ready[ch] !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk("accept_wait_timeout", ch, 32'(n >= 1000), 32'd0);
        step();
        acc[ch]      = cyc;
        tx_valid[ch] = 1'b0;
    endtask

    function automatic logic [7:0] last_got(input int ch);
        int i;
        if (ch == 0) begin
            i = g_periph[0].gcnt - 1;
            return g_periph[0].got[(i < 0 ? 0 : i) % 16];
        end
        i = g_periph[1].gcnt - 1;
        return g_periph[1].got[(i < 0 ? 0 : i) % 16];
    endfunction

    logic [7:0] f_tx [3];
    logic [7:0] f_mi [3];
    int         n_before;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        f_tx = '{8'h01, 8'h02, 8'h03};
        f_mi = '{8'hC1, 8'hC2, 8'hC3};
        for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < 4; j++) tab[c][j] = 8'h00;
            widx[c] = 0; acc[c] = 0;
        end
        tx_valid = '0; tx_last = '0; tx_data = '0; drv_miso = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wait_to(cyc + 1);
        chk("reset_ss",       0, 32'(ss[0]),       32'd1);
        chk("reset_busy",     0, 32'(busy[0]),     32'd0);
        chk("reset_tx_ready", 0, 32'(tx_ready[0]), 32'd1);
        chk("reset_rx_data",  0, 32'(rx_data[0]),  32'h00);
        step();

        // Single byte A5, peripheral answers 3C.
        send_byte(0, 8'hA5, 1'b1, 8'h3C);
        wait_to(acc[0] + 67);
        chk("a5_rxv_before_68", 0, 32'(rx_valid[0]), 32'd0);
        wait_to(acc[0] + 68);
        chk("a5_rxv_at_68",     0, 32'(rx_valid[0]), 32'd1);
        chk("a5_rx_data",       0, 32'(rx_data[0]),  32'h3C);
        wait_to(acc[0] + 71);
        chk("a5_ss_hold",       0, 32'(ss[0]),       32'd0);
        wait_to(acc[0] + 72);
        chk("a5_ss_release",    0, 32'(ss[0]),       32'd1);
        wait_to(acc[0] + 80);
        chk("a5_periph_rx",     0, 32'(last_got(0)), 32'hA5);
        step();

        // Three-byte frame, idle gaps in WAIT_NEXT between bytes.
        for (int i = 0; i < 3; i++) begin
            send_byte(0, f_tx[i], (i == 2), f_mi[i]);
            wait_to(acc[0] + 68);
            chk("frame_rxv",     i, 32'(rx_valid[0]), 32'd1);
            chk("frame_rx_data", i, 32'(rx_data[0]),  32'(f_mi[i]));
            if (i < 2) begin
                wait_to(acc[0] + 75);
                chk("frame_wait_ready", i, 32'(tx_ready[0]), 32'd1);
                chk("frame_wait_ss",    i, 32'(ss[0]),       32'd0);
            end else begin
                wait_to(acc[0] + 80);
            end
            chk("frame_periph_rx", i, 32'(last_got(0)), 32'(f_tx[i]));
            step();
        end

        // tx_valid with FF offered while the controller is mid-byte.
        send_byte(0, 8'h00, 1'b1, 8'h96);
        wait_to(acc[0] + 5);
        step();
        tx_data[0] = 8'hFF; tx_last[0] = 1'b0; tx_valid[0] = 1'b1;
        wait_to(acc[0] + 7);
        chk("busy_in_sck_high",  0, 32'(busy[0]),     32'd1);
        chk("ready_in_sck_high", 0, 32'(tx_ready[0]), 32'd0);
        wait_to(acc[0] + 50);
        step();
        tx_valid[0] = 1'b0;
        wait_to(acc[0] + 68);
        chk("ignore_rx_data",   0, 32'(rx_data[0]),  32'h96);
        wait_to(acc[0] + 80);
        chk("ignore_periph_rx", 0, 32'(last_got(0)), 32'h00);
        step();

        // Reset landing on rising edge 30 of a byte.
        n_before = m_rxvn[0];
        send_byte(0, 8'hA5, 1'b1, 8'h3C);
        wait_to(acc[0] + 28);
        step();
        rst = 1'b1;
        wait_to(acc[0] + 30);
        chk("abort_ss",       0, 32'(ss[0]),       32'd1);
        chk("abort_sck",      0, 32'(sck[0]),      32'd0);
        chk("abort_rxv",      0, 32'(rx_valid[0]), 32'd0);
        chk("abort_mosi",     0, 32'(mosi[0]),     32'd0);
        chk("abort_tx_ready", 0, 32'(tx_ready[0]), 32'd0);
        step();
        rst = 1'b0;
        wait_to(acc[0] + 32);
        chk("abort_ready_after_release", 0, 32'(tx_ready[0]), 32'd1);
        wait_to(acc[0] + 120);
        chk("abort_no_rx_pulse", 0, 32'(m_rxvn[0] - n_before), 32'd0);
        chk("abort_rx_cleared",  0, 32'(rx_data[0]), 32'h00);
        step();

        // CLK_DIV=1 instance, byte 81.
        send_byte(1, 8'h81, 1'b1, 8'h7E);
        wait_to(acc[1] + 16);
        chk("div1_rxv_before_17", 1, 32'(rx_valid[1]), 32'd0);
        wait_to(acc[1] + 17);
        chk("div1_rxv_at_17",     1, 32'(rx_valid[1]), 32'd1);
        chk("div1_rx_data",       1, 32'(rx_data[1]),  32'h7E);
        wait_to(acc[1] + 25);
        chk("div1_periph_rx",     1, 32'(last_got(1)), 32'h81);
        step();

`ifdef SPI_CTRL_LOOPBACK_EN
        lb = 1'b1;
        send_byte(0, 8'h5A, 1'b1, 8'h00);
        wait_to(acc[0] + 68);
        chk("loopback_rx_data", 0, 32'(rx_data[0]), 32'h5A);
        wait_to(acc[0] + 80);
        step();
        lb = 1'b0;
`endif

        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spi_controller
`default_nettype wire
